// File: rtl/hamming_pkg.sv
// Shared widths, codeword bit positions and Hamming(7,4) helper functions.
// Defining HAMMING_SECDED_EN widens the codeword by one overall-parity bit.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;
  localparam int HAM_W  = 7;
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = 8;
`else
  localparam int CODE_W = 7;
`endif

  // Hamming positions (1-based) that carry d0..d3
  localparam int D0_POS = 3;
  localparam int D1_POS = 5;
  localparam int D2_POS = 6;
  localparam int D3_POS = 7;

  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [HAM_W-1:0] code);
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int k = 1; k <= HAM_W; k++) begin
      for (int j = 0; j < SYN_W; j++) begin
        if (((k >> j) & 1) != 0) syn[j] = syn[j] ^ code[k-1];
      end
    end
    return syn;
  endfunction

  // One-hot mask selecting the Hamming position named by the syndrome; zero for syndrome 0.
  function automatic logic [HAM_W-1:0] flip_mask(input logic [SYN_W-1:0] syn);
    logic [HAM_W-1:0] mask;
    mask = '0;
    for (int k = 1; k <= HAM_W; k++) begin
      if (int'(syn) == k) mask[k-1] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [HAM_W-1:0] code);
    return {code[D3_POS-1], code[D2_POS-1], code[D1_POS-1], code[D0_POS-1]};
  endfunction

endpackage

// File: rtl/module_hamming_syndrome.sv
// Combinational syndrome generator; with HAMMING_SECDED_EN also produces the
// overall even-parity check across all eight codeword bits.
module module_hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syndrome
`ifdef HAMMING_SECDED_EN
  ,
  output logic              parity
`endif
);

  assign syndrome = calc_syndrome(code[HAM_W-1:0]);

`ifdef HAMMING_SECDED_EN
  assign parity = ^code;
`endif

endmodule

// File: rtl/module_hamming_dec.sv
// Two-stage valid/ready Hamming decoder (2-cycle latency, full-throughput backpressure)
// with sticky error flag and saturating error counter; HAMMING_SECDED_EN adds DED.
module module_hamming_dec
  import hamming_pkg::*;
#(
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [SYN_W-1:0]     syndrome,
  output logic                 dbl_error,
  output logic                 bit_error,
  input  logic                 err_clear,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [SYN_W-1:0]  in_syn;
  logic              s1_vld;
  logic [HAM_W-1:0]  s1_code;
  logic [SYN_W-1:0]  s1_syn;
  logic              s2_vld;
  logic [DATA_W-1:0] s2_data;
  logic [SYN_W-1:0]  s2_syn;
  logic              s2_free;
  logic              s1_move;
  logic              word_err;
  logic              word_dbl;
  logic              err_load;
  logic [HAM_W-1:0]  fix;
  logic [DATA_W-1:0] corr_data;

`ifdef HAMMING_SECDED_EN
  logic in_par;
  logic s1_par;
  logic s2_dbl;

  module_hamming_syndrome u_syndrome (
    .code     (in_code),
    .syndrome (in_syn),
    .parity   (in_par)
  );
`else
  module_hamming_syndrome u_syndrome (
    .code     (in_code),
    .syndrome (in_syn)
  );
`endif

  assign s2_free  = !s2_vld || out_ready;
  assign s1_move  = s1_vld && s2_free;
  assign in_ready = !s1_vld || s1_move;

  // Only a confirmed single error (odd overall parity under SECDED) is corrected.
  always_comb begin
    fix      = '0;
    word_err = 1'b0;
    word_dbl = 1'b0;
`ifdef HAMMING_SECDED_EN
    if (s1_syn != '0 && s1_par) fix = flip_mask(s1_syn);
    word_dbl = (s1_syn != '0) && !s1_par;
    word_err = (s1_syn != '0) || s1_par;
`else
    fix      = flip_mask(s1_syn);
    word_err = (s1_syn != '0);
`endif
    corr_data = extract_data(s1_code ^ fix);
  end

  assign err_load = s1_move && word_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_code <= '0;
      s1_syn  <= '0;
`ifdef HAMMING_SECDED_EN
      s1_par  <= 1'b0;
`endif
    end else if (in_ready) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_code <= in_code[HAM_W-1:0];
        s1_syn  <= in_syn;
`ifdef HAMMING_SECDED_EN
        s1_par  <= in_par;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_data <= '0;
      s2_syn  <= '0;
`ifdef HAMMING_SECDED_EN
      s2_dbl  <= 1'b0;
`endif
    end else if (s2_free) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_data <= corr_data;
        s2_syn  <= s1_syn;
`ifdef HAMMING_SECDED_EN
        s2_dbl  <= word_dbl;
`endif
      end
    end
  end

  // A clear coinciding with an erroneous load still records that new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_error <= 1'b0;
      err_count <= '0;
    end else if (err_clear) begin
      bit_error <= err_load;
      err_count <= err_load ? ERR_CNT_W'(1) : '0;
    end else if (err_load) begin
      bit_error <= 1'b1;
      if (!(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign out_valid = s2_vld;
  assign out_data  = s2_data;
  assign syndrome  = s2_syn;
`ifdef HAMMING_SECDED_EN
  assign dbl_error = s2_dbl;
`else
  assign dbl_error = 1'b0;
  logic unused_dbl;
  assign unused_dbl = word_dbl;
`endif

endmodule
